// File: rtl/mem_io_responder_pkg.sv
// Shared constants for the CPU-side memory/IO responder: IO window decode,
// register offsets and stop-sequence state encodings.
package mem_io_responder_pkg;

   localparam logic [1:0]  IO_SEL      = 2'b11;
   localparam logic [15:0] IO_UART_OFF = 16'h0000;
   localparam logic [15:0] IO_CLK_OFF  = 16'h0004;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_STOPPING = 2'd1,
      ST_HALTED   = 2'd2
   } stop_state_t;

   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
      return w[8*idx +: 8];
   endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte-wide FIFO with combinational head output; push is accepted while full
// when a pop happens in the same cycle.
module mem_io_responder_byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               din,
   output logic [7:0]               dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic [$clog2(DEPTH):0]   count_next
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [7:0]    mem [0:DEPTH-1];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          pop_ok;
   logic          push_ok;

   assign empty  = (count_reg == '0);
   assign full   = (count_reg == FULL_CNT);
   assign pop_ok = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign dout   = mem[rd_ptr_reg];
   assign count  = count_reg;

   always_comb begin
      count_next = count_reg;
      case ({push_ok, pop_ok})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr_reg] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side end of the CPU byte bus: 128KB RAM, UART tx/rx FIFOs,
// free-running cycle counter and the program-stop handshake.
module mem_io_responder
   import mem_io_responder_pkg::*;
#(
   parameter int RAM_ADDR_W  = 17,
   parameter int TX_DEPTH    = 16,
   parameter int RX_DEPTH    = 16,
   parameter int FULL_MARGIN = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] cpu_a,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_wr,
   output logic [7:0]  cpu_din,
   output logic        io_buffer_full,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        program_stop
);

   localparam int TX_CW = $clog2(TX_DEPTH) + 1;
   localparam int RX_CW = $clog2(RX_DEPTH) + 1;

   logic [7:0]  ram [0:(1<<RAM_ADDR_W)-1];
   logic [7:0]  ram_q_reg;
   logic        sel_ram_reg;
   logic [7:0]  io_q_reg;
   logic [31:0] counter_reg;
   logic [31:0] snap_reg;
   logic        io_full_reg;
   stop_state_t state_reg, state_next;
   logic        stop_pushed_reg, stop_pushed_next;

   logic        io_sel;
   logic [15:0] io_off;
   logic        uart_hit;
   logic        clk_hit;
   logic        stop_hit;
   logic        ram_sel;
   logic [7:0]  io_rd_data;

   logic             tx_push, tx_pop, tx_empty, tx_full;
   logic [7:0]       tx_din, tx_dout;
   logic [TX_CW-1:0] tx_count, tx_count_next, tx_free_next;
   logic             rx_push, rx_pop, rx_empty, rx_full;
   logic [7:0]       rx_dout;
   logic [RX_CW-1:0] rx_count, rx_count_next;
   logic             unused_ok;

   assign io_sel   = (cpu_a[17:16] == IO_SEL);
   assign io_off   = cpu_a[15:0];
   assign uart_hit = io_sel && (io_off == IO_UART_OFF);
   assign clk_hit  = io_sel && (io_off[15:2] == IO_CLK_OFF[15:2]);
   assign stop_hit = io_sel && (io_off == IO_CLK_OFF);
   assign ram_sel  = !io_sel;

   assign unused_ok = ^{cpu_a[31:18], tx_count, rx_count, rx_count_next};

   mem_io_responder_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk        (clk_in),
      .rst        (rst_in),
      .push       (tx_push),
      .pop        (tx_pop),
      .din        (tx_din),
      .dout       (tx_dout),
      .empty      (tx_empty),
      .full       (tx_full),
      .count      (tx_count),
      .count_next (tx_count_next)
   );

   mem_io_responder_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk        (clk_in),
      .rst        (rst_in),
      .push       (rx_push),
      .pop        (rx_pop),
      .din        (rx_data),
      .dout       (rx_dout),
      .empty      (rx_empty),
      .full       (rx_full),
      .count      (rx_count),
      .count_next (rx_count_next)
   );

   assign tx_valid = !tx_empty;
   assign tx_data  = tx_dout;
   assign tx_pop   = tx_valid && tx_ready;
   assign rx_ready = !rx_full;
   assign rx_push  = rx_valid && rx_ready;
   assign rx_pop   = !cpu_wr && uart_hit;

   // Free entries counted after this cycle's push/pop, so the CPU sees the
   // flag early enough to cover writes already in its pipeline.
   assign tx_free_next = TX_CW'(TX_DEPTH) - tx_count_next;

   // Stop sequence: the 0x00 marker is the only zero byte that can ever
   // enter the tx FIFO, so seeing it popped marks the end of output.
   always_comb begin
      state_next       = state_reg;
      stop_pushed_next = stop_pushed_reg;
      tx_push          = 1'b0;
      tx_din           = cpu_dout;
      case (state_reg)
         ST_RUN: begin
            if (cpu_wr && uart_hit && (cpu_dout != 8'h00))
               tx_push = 1'b1;
            if (cpu_wr && stop_hit)
               state_next = ST_STOPPING;
         end
         ST_STOPPING: begin
            if (!stop_pushed_reg) begin
               tx_push = 1'b1;
               tx_din  = 8'h00;
               if (!tx_full || tx_pop)
                  stop_pushed_next = 1'b1;
            end else if (tx_pop && (tx_dout == 8'h00)) begin
               state_next = ST_HALTED;
            end
         end
         ST_HALTED: begin
            state_next = ST_HALTED;
         end
         default: state_next = ST_RUN;
      endcase
   end

   always_comb begin
      io_rd_data = 8'h00;
      if (uart_hit)
         io_rd_data = rx_empty ? 8'h00 : rx_dout;
      else if (clk_hit)
         io_rd_data = (io_off[1:0] == 2'b00) ? counter_reg[7:0]
                                             : word_byte(snap_reg, io_off[1:0]);
   end

   always_ff @(posedge clk_in) begin
      if (cpu_wr && ram_sel)
         ram[cpu_a[RAM_ADDR_W-1:0]] <= cpu_dout;
      if (!cpu_wr && ram_sel)
         ram_q_reg <= ram[cpu_a[RAM_ADDR_W-1:0]];
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sel_ram_reg     <= 1'b0;
         io_q_reg        <= 8'h00;
         counter_reg     <= 32'd0;
         snap_reg        <= 32'd0;
         io_full_reg     <= 1'b0;
         state_reg       <= ST_RUN;
         stop_pushed_reg <= 1'b0;
      end else begin
         counter_reg     <= counter_reg + 32'd1;
         io_full_reg     <= (tx_free_next <= TX_CW'(FULL_MARGIN));
         state_reg       <= state_next;
         stop_pushed_reg <= stop_pushed_next;
         if (!cpu_wr) begin
            sel_ram_reg <= ram_sel;
            io_q_reg    <= io_rd_data;
         end
         if (!cpu_wr && stop_hit)
            snap_reg <= counter_reg;
      end
   end

   // RAM read data lives in the unreset block RAM output register; the
   // select flag picks it or the IO read register without adding latency.
   assign cpu_din        = sel_ram_reg ? ram_q_reg : io_q_reg;
   assign io_buffer_full = io_full_reg;
   assign program_stop   = (state_reg == ST_HALTED);

endmodule
